// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction-fetch sequencer.
package fetch_pkg;
   localparam int PC_W    = 32;
   localparam int INSTR_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_t;
endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry decode-facing output buffer with a one-entry skid register behind it.
module fetch_skid_buffer
   import fetch_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               flush,
   input  logic               load,
   input  logic [INSTR_W-1:0] load_instr,
   input  logic [PC_W-1:0]    load_pc,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [PC_W-1:0]    if_pc
);
   logic               skid_valid;
   logic [INSTR_W-1:0] skid_instr;
   logic [PC_W-1:0]    skid_pc;
   logic               consume;
   logic               buf_free;

   assign consume  = if_valid & ~stall;
   assign buf_free = ~if_valid | ~stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_valid   <= 1'b0;
         if_instr   <= '0;
         if_pc      <= '0;
         skid_valid <= 1'b0;
         skid_instr <= '0;
         skid_pc    <= '0;
      end else if (flush) begin
         if_valid   <= 1'b0;
         skid_valid <= 1'b0;
      end else if (load) begin
         // the sequencer only loads while the skid is empty
         if (buf_free) begin
            if_valid <= 1'b1;
            if_instr <= load_instr;
            if_pc    <= load_pc;
         end else begin
            skid_valid <= 1'b1;
            skid_instr <= load_instr;
            skid_pc    <= load_pc;
         end
      end else if (consume) begin
         if (skid_valid) begin
            if_instr   <= skid_instr;
            if_pc      <= skid_pc;
            skid_valid <= 1'b0;
         end else begin
            if_valid <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC and sequences it against a hold-until-ready imem handshake.
//   state | meaning
//   IDLE  | no request; start fetching next cycle
//   REQ   | request outstanding at imem_addr
//   HOLD  | buffer and skid full; wait for decode to consume
//   DRAIN | finish a request abandoned by redirect, drop its data
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [PC_W-1:0] PC_INC   = 32'd1
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ready,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               stall,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [PC_W-1:0]    if_pc,
   output logic [PC_W-1:0]    pc
);
   fetch_state_t    state;
   logic [PC_W-1:0] fetch_pc;
   logic [PC_W-1:0] next_pc;
   logic            buf_free;
   logic            consume;
   logic            load;

   assign next_pc  = fetch_pc + PC_INC;
   assign buf_free = ~if_valid | ~stall;
   assign consume  = if_valid & ~stall;
   assign load     = (state == REQ) & imem_ready & ~redirect_valid;
   assign pc       = fetch_pc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         fetch_pc  <= RESET_PC;
         imem_req  <= 1'b0;
         imem_addr <= '0;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_pc;
         imem_req <= 1'b1;
         // an unfinished request must still complete before the new target goes out
         if ((state == REQ || state == DRAIN) && !imem_ready) begin
            state <= DRAIN;
         end else begin
            state     <= REQ;
            imem_addr <= redirect_pc;
         end
      end else begin
         case (state)
            IDLE: begin
               state     <= REQ;
               imem_req  <= 1'b1;
               imem_addr <= fetch_pc;
            end
            REQ: begin
               if (imem_ready) begin
                  fetch_pc <= next_pc;
                  if (buf_free) begin
                     imem_addr <= next_pc;
                  end else begin
                     state    <= HOLD;
                     imem_req <= 1'b0;
                  end
               end
            end
            HOLD: begin
               if (consume) begin
                  state     <= REQ;
                  imem_req  <= 1'b1;
                  imem_addr <= fetch_pc;
               end
            end
            DRAIN: begin
               if (imem_ready) begin
                  state     <= REQ;
                  imem_addr <= fetch_pc;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   fetch_skid_buffer u_skid (
      .clk        (clk),
      .rst        (reset),
      .stall      (stall),
      .flush      (redirect_valid),
      .load       (load),
      .load_instr (imem_rdata),
      .load_pc    (imem_addr),
      .if_valid   (if_valid),
      .if_instr   (if_instr),
      .if_pc      (if_pc)
   );
endmodule
